// File: rtl/skolem_parity_checker_pkg.sv
// skolem_parity_checker_pkg: shared FSM state type and parameter defaults
package skolem_parity_checker_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    localparam int N_IN_DEF  = 6;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/skolem_parity_checker_sat_counter.sv
// sat_counter: saturating up-counter, clr beats inc
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up by one unless already all-ones
//   clr      : clear to zero, wins over inc
//   count    : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/skolem_parity_checker.sv
// skolem_parity_checker: bit-serial check that the XOR of all N_IN+1 word bits is 1
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input word handshake, in_word[N_IN] is the candidate output
//   res_valid/res_ready  : verdict handshake, res_ok = 1 when the relation holds
//   clr_cnt              : one-cycle pulse clearing both statistics counters
//   word_cnt, err_cnt    : saturating counts of delivered / failing verdicts
module skolem_parity_checker
    import skolem_parity_checker_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN:0]   in_word,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_ok,
    input  logic            clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int BW = $clog2(N_IN + 2);

    state_t        state, state_n;
    logic [N_IN:0] shift, shift_n;
    logic          acc, acc_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          done;

    assign in_ready  = state == IDLE;
    assign res_valid = state == REPORT;
    assign res_ok    = res_valid & acc;
    assign done      = res_valid & res_ready;

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            shift <= '0;
            acc   <= 1'b0;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            acc   <= acc_n;
            bcnt  <= bcnt_n;
        end

    always_comb begin
        state_n = state;
        shift_n = shift;
        acc_n   = acc;
        bcnt_n  = bcnt;
        case (state)
            IDLE:
                if (in_valid) begin
                    state_n = SHIFT;
                    shift_n = in_word;
                    acc_n   = 1'b0;
                    bcnt_n  = '0;
                end
            SHIFT: begin
                acc_n   = acc ^ shift[0];
                shift_n = shift >> 1;
                bcnt_n  = bcnt + BW'(1);
                // bcnt == N_IN marks the (N_IN+1)-th and final bit
                state_n = bcnt == BW'(N_IN) ? REPORT : SHIFT;
            end
            REPORT:
                state_n = done ? IDLE : REPORT;
            default:
                state_n = IDLE;
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (done),
        .clr   (clr_cnt),
        .count (word_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (done & ~acc),
        .clr   (clr_cnt),
        .count (err_cnt)
    );
endmodule

// File: tb/tb_skolem_parity_checker.sv
// tb_skolem_parity_checker: directed vector table plus multi-cycle corner sequences
module tb_skolem_parity_checker;
    localparam int N = 6;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic         clr_cnt = 1'b0;
    logic [N:0]   in_word = '0;
    logic         in_ready, res_valid, res_ok;
    logic [W-1:0] word_cnt, err_cnt;

    skolem_parity_checker #(.N_IN(N), .CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .clr_cnt   (clr_cnt),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] word;
        logic       ok;
    } vec_t;

    vec_t vecs[8];
    int nvec = 0;
    int nmis = 0;
    int exp_w = 0;
    int exp_e = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_hs(input logic ok);
        if (exp_w < 255) exp_w++;
        if (!ok && exp_e < 255) exp_e++;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, " word_cnt"}, 32'(word_cnt), 32'(exp_w));
        chk({name, " err_cnt"}, 32'(err_cnt), 32'(exp_e));
    endtask

    // Send one word with res_ready high; optionally pulse clr_cnt on SHIFT cycle clr_at+1.
    task automatic run_word(input logic [N:0] w, input logic ok, input int clr_at, input string name);
        int lat;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_word   = w;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            clr_cnt = (lat == clr_at);
            @(negedge clk);
            lat++;
        end
        clr_cnt = 1'b0;
        if (clr_at >= 0 && clr_at < N + 1) begin
            exp_w = 0;
            exp_e = 0;
        end
        chk({name, " latency"}, 32'(lat), 32'(N + 1));
        chk({name, " res_ok"}, 32'(res_ok), 32'(ok));
        @(negedge clk);
        model_hs(ok);
        chk({name, " res_valid after hs"}, 32'(res_valid), 32'd0);
        chk_cnt(name);
    endtask

    initial begin
        int lat, hs, first, last;
        logic seen;
        vecs[0] = '{7'b0000001, 1'b1};
        vecs[1] = '{7'b0000000, 1'b0};
        vecs[2] = '{7'b1111111, 1'b1};
        vecs[3] = '{7'b0111111, 1'b0};
        vecs[4] = '{7'b0101010, 1'b1};
        vecs[5] = '{7'b1000000, 1'b1};
        vecs[6] = '{7'b0000011, 1'b0};
        vecs[7] = '{7'b1010101, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_ok", 32'(res_ok), 32'd0);
        chk_cnt("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_word(vecs[i].word, vecs[i].ok, -1, $sformatf("vec%0d", i));

        // verdict held while res_ready low; in_valid kept high must be ignored
        @(negedge clk);
        in_valid  = 1'b1;
        in_word   = 7'b0000000;
        res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hold latency", 32'(lat), 32'(N + 1));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d res_valid", k), 32'(res_valid), 32'd1);
            chk($sformatf("hold%0d res_ok", k), 32'(res_ok), 32'd0);
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            chk_cnt($sformatf("hold%0d", k));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        model_hs(1'b0);
        chk("hold release res_valid", 32'(res_valid), 32'd0);
        chk_cnt("hold release");

        // reset during SHIFT cycle 3 drops the word
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 7'b0000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_w = 0;
        exp_e = 0;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset res_valid", 32'(res_valid), 32'd0);
        chk_cnt("midreset");
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= res_valid;
        end
        chk("midreset no verdict", 32'(seen), 32'd0);

        // stream 260 all-zero words back to back
        in_valid  = 1'b1;
        in_word   = '0;
        res_ready = 1'b1;
        hs = 0;
        first = 0;
        last = 0;
        for (int c = 0; c < 260 * (N + 3) + 50 && hs < 260; c++) begin
            @(negedge clk);
            if (res_valid) begin
                if (hs == 0) first = c;
                last = c;
                hs++;
                model_hs(1'b0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream handshakes", 32'(hs), 32'd260);
        chk("stream period", 32'(last - first), 32'(259 * (N + 3)));
        chk("stream word_cnt sat", 32'(word_cnt), 32'd255);
        chk("stream err_cnt sat", 32'(err_cnt), 32'd255);
        chk_cnt("stream");

        // clear mid-flight must not disturb the verdict
        run_word(7'b0000001, 1'b1, 2, "clr_shift");

        // clear coinciding with a report handshake wins
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 7'b0000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_hs latency", 32'(lat), 32'(N + 1));
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        exp_w = 0;
        exp_e = 0;
        chk("clr_hs res_valid", 32'(res_valid), 32'd0);
        chk_cnt("clr_hs");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/skolem_parity_checker.md
SKOLEM_PARITY_CHECKER -- requirements
Module: skolem_parity_checker

Interface
REQ-001 SHALL have parameter N_IN, default 6, meaning the number of Skolem-function input bits per word.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each statistics counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_word is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: checker can accept a word.
REQ-007 SHALL have port in_word, input, N_IN+1 bits: bits [N_IN-1:0] = i0..i(N_IN-1); bit [N_IN] = candidate output i(N_IN).
REQ-008 SHALL have port res_valid, output, 1 bit: verdict is available.
REQ-009 SHALL have port res_ready, input, 1 bit: consumer takes the verdict.
REQ-010 SHALL have port res_ok, output, 1 bit: 1 = candidate output satisfies the XNOR-chain relation.
REQ-011 SHALL have port clr_cnt, input, 1 bit: single-cycle pulse that clears both counters.
REQ-012 SHALL have port word_cnt, output, CNT_W bits: number of verdicts delivered.
REQ-013 SHALL have port err_cnt, output, CNT_W bits: number of verdicts delivered with res_ok=0.

Function
REQ-014 SHALL treat a word as correct iff i(N_IN) = NOT(i0 XOR ... XOR i(N_IN-1)), i.e. the XOR of all N_IN+1 bits equals 1.
REQ-015 SHALL evaluate bit-serially, one bit per cycle, LSB first; no combinational N_IN-wide XOR tree.
REQ-016 SHALL implement FSM states: IDLE, SHIFT, REPORT.
REQ-017 IDLE: in_ready=1. On in_valid&in_ready: load shift register with in_word; accumulator=0; bit counter=0; next state SHIFT.
REQ-018 SHIFT: in_ready=0. Each cycle: accumulator ^= shift[0]; shift >>= 1; bit counter +1. After N_IN+1 SHIFT cycles: next state REPORT.
REQ-019 REPORT: res_valid=1; res_ok=accumulator. Both SHALL stay stable until res_valid&res_ready. On that handshake: next state IDLE.
REQ-020 Latency SHALL be N_IN+1 cycles: res_valid rises exactly N_IN+1 clock edges after the accepting edge (7 for the default).
REQ-021 With res_ready held high and in_valid continuously asserted, throughput SHALL be one word per N_IN+3 cycles.
REQ-022 in_ready SHALL be 0 in SHIFT and REPORT; in_valid in those states SHALL be ignored.
REQ-023 On a report handshake: word_cnt SHALL increment; err_cnt SHALL increment iff res_ok=0.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 If clr_cnt coincides with an increment, clear SHALL win and the counter SHALL read 0.
REQ-026 clr_cnt SHALL NOT affect the FSM or an in-flight word.

Reset
REQ-027 When rst=1 at a clock edge: state=IDLE; shift register, accumulator, bit counter, word_cnt and err_cnt SHALL be 0.
REQ-028 During and after reset: in_ready=1, res_valid=0, res_ok=0.
REQ-029 Reset in SHIFT or REPORT SHALL discard the in-flight word; no verdict is emitted and no counter is updated.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the N_IN default and the counter width default.
REQ-031 A saturating counter SHALL be one sub-module, sat_counter (parameter width; ports inc, clr; clr has priority), instantiated twice.

Verification
REQ-032 in_word=7'b0000001 (i0=1), res_ready=1 -> res_valid after 7 cycles, res_ok=1, word_cnt=1, err_cnt=0.
REQ-033 in_word=7'b0000000 -> res_ok=0, err_cnt increments to 1.
REQ-034 in_word=7'b1111111 -> res_ok=1; in_word=7'b0111111 -> res_ok=0.
REQ-035 res_ready held low 5 cycles in REPORT -> res_valid and res_ok stable, in_ready=0 throughout, counters unchanged until the handshake.
REQ-036 rst asserted on SHIFT cycle 3 -> IDLE next cycle, no res_valid, counters 0; an all-zero word streamed 260 times -> err_cnt=word_cnt=255 (saturated); clr_cnt pulsed on a report handshake -> both counters read 0.
